reduce_gate_pipe: RTL

- Parametrised successor to the single-clock registered 6-input OR gate.
- Registered reduction of a WIDTH-bit input vector with a run-time selectable logic operation.
- Two modes:
  - direct: one result per input sample.
  - window: one result per WINDOW accepted samples, folded together.
- Valid/ready handshake on both sides, so the block drops into streaming datapaths fed by switch or sensor sampling logic.

---
 rtl/reduce_ops_pkg.sv | 46 ++++
 rtl/reduce_gate_pipe_unit.sv | 22 ++
 rtl/reduce_gate_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/reduce_ops_pkg.sv
// Operation encodings and helpers for the reduce_gate_pipe family.
// Shared by the fold unit and the streaming top.
package reduce_ops_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    B_AND = 2'd0,
    B_OR  = 2'd1,
    B_XOR = 2'd2
  } base_e;

  function automatic base_e base_op(input logic [2:0] op);
    base_e b;
    b = B_OR;
    unique case (1'b1)
      op == OP_AND || op == OP_NAND: b = B_AND;
      op == OP_XOR || op == OP_XNOR: b = B_XOR;
      default:                       b = B_OR;
    endcase
    return b;
  endfunction

  function automatic logic is_inverted(input logic [2:0] op);
    return op == OP_NAND || op == OP_NOR || op == OP_XNOR;
  endfunction

  function automatic logic combine(input base_e b,
                                   input logic  x,
                                   input logic  y);
    logic r;
    r = x | y;
    unique case (1'b1)
      b == B_AND: r = x & y;
      b == B_XOR: r = x ^ y;
      default:    r = x | y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_gate_pipe_unit.sv
// Combinational WIDTH-bit fold with a base AND/OR/XOR operation.
// Inversion for NAND/NOR/XNOR is applied by the caller.
module reduce_unit
  import reduce_ops_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] data_in,
  input  base_e            base_in,
  output logic             r_out
);

  always_comb begin
    r_out = |data_in;
    unique case (1'b1)
      base_in == B_AND: r_out = &data_in;
      base_in == B_XOR: r_out = ^data_in;
      default:          r_out = |data_in;
    endcase
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Registered WIDTH-bit reduction with direct and windowed modes
// behind valid/ready handshakes on both sides.
module reduce_gate_pipe
  import reduce_ops_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int WINDOW = 4,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       op_in,
  input  logic             mode_in,
  input  logic             clear_in,
  output logic             result_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] count_out
);

  logic [2:0]       op_q;
  logic             mode_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic       win_start;
  logic [2:0] op_eff;
  logic       mode_eff;
  base_e      base_eff;
  logic       inv_eff;
  logic       r;
  logic       acc_next;
  logic       accept;
  logic       last;
  logic       win_acc;
  logic       dir_acc;
  logic       emit;

  // op/mode are only taken from the inputs at a window boundary
  assign win_start = cnt_q == '0;
  assign op_eff    = win_start ? op_in : op_q;
  assign mode_eff  = win_start ? mode_in : mode_q;
  assign base_eff  = base_op(op_eff);
  assign inv_eff   = is_inverted(op_eff);

  reduce_unit #(
    .WIDTH(WIDTH)
  ) u_fold (
    .data_in (data_in),
    .base_in (base_eff),
    .r_out   (r)
  );

  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out;
  assign acc_next  = win_start ? r : combine(base_eff, acc_q, r);
  assign last      = cnt_q == CNT_W'(WINDOW - 1);
  assign win_acc   = accept && mode_eff && !clear_in;
  assign dir_acc   = accept && !mode_eff;
  assign emit      = dir_acc || (win_acc && last);
  assign count_out = cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      op_q       <= OP_OR;
      mode_q     <= 1'b0;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      result_out <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      if (accept && win_start && !clear_in) begin
        op_q   <= op_in;
        mode_q <= mode_in;
      end
      if (clear_in) begin
        cnt_q <= '0;
        acc_q <= 1'b0;
      end else if (win_acc) begin
        acc_q <= acc_next;
        cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
      end
      // a new result overrides the pending one being consumed this edge
      if (emit) begin
        result_out <= acc_next ^ inv_eff;
        valid_out  <= 1'b1;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
